// File: rtl/pio_in_pkg.sv
// pio_in_pkg: shared types, timing defaults and counter sizing helper for the
// PIO input conditioner.
//   hold_state_e : per-button hold/auto-repeat FSM states
//   cnt_width()  : bits needed to hold values 0..max_val (minimum 1)
//   CLK_HZ, DB_MS, HOLD_MS, REPEAT_MS : defaults used to derive cycle counts
package pio_in_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned DB_MS     = 10;
  localparam int unsigned HOLD_MS   = 500;
  localparam int unsigned REPEAT_MS = 100;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_PRESSED = 2'd1,
    HS_HELD    = 2'd2
  } hold_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one input channel -- 2-FF synchroniser, optional polarity
// inversion, and a counter-based debouncer.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : asynchronous pin
//   level_o : debounced, polarity-normalised level (1 = active)
//   rise_o  : 1-cycle strobe, registered on the edge level_o rises
//   fall_o  : 1-cycle strobe, registered on the edge level_o falls
module debounce_ch
  import pio_in_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 8,
  parameter bit          INVERT    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DC_W = cnt_width(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            s;
  logic            st_q, st_d;
  logic [DC_W-1:0] dc_q, dc_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Synchroniser resets to the inactive raw level so no false edge is seen.
  assign s = sync_q[1] ^ INVERT;

  always_comb begin
    st_d   = st_q;
    dc_d   = dc_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == st_q) begin
      dc_d = '0;
    end else if (dc_q == DC_W'(DB_CYCLES - 1)) begin
      st_d   = s;
      dc_d   = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      dc_d = dc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{INVERT}};
      st_q   <= 1'b0;
      dc_q   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      st_q   <= st_d;
      dc_q   <= dc_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = st_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: conditions raw buttons and switches ahead of the
// tarea1 PIO inputs. Every channel is synchronised and debounced; buttons
// additionally produce press/release strobes and hold/auto-repeat pulses.
//   clk_clk       : system clock
//   reset_reset_n : asynchronous active-low reset
//   btn_raw       : raw button pins (polarity set by BTN_ACTIVE_LOW)
//   sw_raw        : raw switch pins (1 = on)
//   btn_level     : debounced button state, 1 = pressed
//   sw_level      : debounced switch state
//   btn_press     : 1-cycle pulse when btn_level rises
//   btn_release   : 1-cycle pulse when btn_level falls
//   btn_hold      : 1-cycle pulse at hold threshold, then every repeat interval
module pio_input_conditioner
  import pio_in_pkg::*;
#(
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned N_SW           = 4,
  parameter int unsigned DB_CYCLES      = CLK_HZ / 1000 * DB_MS,
  parameter int unsigned HOLD_CYCLES    = CLK_HZ / 1000 * HOLD_MS,
  parameter int unsigned REPEAT_CYCLES  = CLK_HZ / 1000 * REPEAT_MS,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  localparam int unsigned HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W   = cnt_width(HC_MAX);

  logic [2*N_SW-1:0] sw_edges_unused;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .INVERT   (1'b0)
    ) u_db (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .raw_i  (sw_raw[i]),
      .level_o(sw_level[i]),
      .rise_o (sw_edges_unused[2*i]),
      .fall_o (sw_edges_unused[2*i+1])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    hold_state_e     hs_q, hs_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic            hold_hit;

    debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .INVERT   (BTN_ACTIVE_LOW)
    ) u_db (
      .clk_i  (clk_clk),
      .rst_ni (reset_reset_n),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .rise_o (btn_press[i]),
      .fall_o (btn_release[i])
    );

    // The FSM follows the debounced level: a low level forces IDLE and also
    // masks the hold pulse, so release always wins over a coincident hold.
    always_comb begin
      hs_d     = hs_q;
      hc_d     = hc_q;
      hold_hit = 1'b0;
      if (!btn_level[i]) begin
        hs_d = HS_IDLE;
        hc_d = '0;
      end else begin
        unique case (hs_q)
          HS_IDLE: begin
            hs_d = HS_PRESSED;
            hc_d = HC_W'(1);
          end
          HS_PRESSED: begin
            if (hc_q == HC_W'(HOLD_CYCLES)) begin
              hold_hit = 1'b1;
              hc_d     = HC_W'(1);
              hs_d     = HS_HELD;
            end else begin
              hc_d = hc_q + 1'b1;
            end
          end
          HS_HELD: begin
            if (REPEAT_CYCLES != 0) begin
              if (hc_q == HC_W'(REPEAT_CYCLES)) begin
                hold_hit = 1'b1;
                hc_d     = HC_W'(1);
              end else begin
                hc_d = hc_q + 1'b1;
              end
            end
          end
          default: begin
            hs_d = HS_IDLE;
            hc_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        hs_q <= HS_IDLE;
        hc_q <= '0;
      end else begin
        hs_q <= hs_d;
        hc_q <= hc_d;
      end
    end

    assign btn_hold[i] = hold_hit;
  end

endmodule

// File: tb/tb_pio_input_conditioner.sv
module tb_pio_input_conditioner;

  localparam int unsigned DB   = 8;
  localparam int unsigned HOLD = 32;
  localparam int unsigned REP  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw, sw_raw;
  logic [3:0] btn_level, sw_level, btn_press, btn_release, btn_hold;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  pio_input_conditioner #(
    .N_BTN         (4),
    .N_SW          (4),
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn_raw      (btn_raw),
    .sw_raw       (sw_raw),
    .btn_level    (btn_level),
    .sw_level     (sw_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_hold     (btn_hold)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples pass through a two-edge delay; a level flips
  // once the delayed value has disagreed with it on DB consecutive edges.
  // Hold pulses occur HOLD edges after a rise, then every REP edges.
  logic [3:0]  mb_d1, mb_d2, ms_d1, ms_d2;
  logic [3:0]  mb_lvl, ms_lvl, m_press, m_rel, m_hold;
  int unsigned mb_run[4], ms_run[4], m_t[4];

  task automatic model_reset();
    mb_d1 = '1; mb_d2 = '1; ms_d1 = '0; ms_d2 = '0;
    mb_lvl = '0; ms_lvl = '0; m_press = '0; m_rel = '0; m_hold = '0;
    for (int i = 0; i < 4; i++) begin
      mb_run[i] = 0; ms_run[i] = 0; m_t[i] = 0;
    end
  endtask

  task automatic step();
    logic [3:0] b, s;
    logic       v;
    b = btn_raw;
    s = sw_raw;
    @(posedge clk);
    if (rst_n) begin
      m_press = '0; m_rel = '0; m_hold = '0;
      for (int i = 0; i < 4; i++) begin
        v = ~mb_d2[i];
        if (v == mb_lvl[i]) mb_run[i] = 0;
        else begin
          mb_run[i]++;
          if (mb_run[i] == DB) begin
            mb_lvl[i] = v;
            mb_run[i] = 0;
            if (v) begin m_press[i] = 1'b1; m_t[i] = 0; end
            else m_rel[i] = 1'b1;
          end
        end
        if (mb_lvl[i] && !m_press[i]) m_t[i]++;
        if (mb_lvl[i] && (m_t[i] == HOLD || (m_t[i] > HOLD && (m_t[i] - HOLD) % REP == 0)))
          m_hold[i] = 1'b1;
        v = ms_d2[i];
        if (v == ms_lvl[i]) ms_run[i] = 0;
        else begin
          ms_run[i]++;
          if (ms_run[i] == DB) begin ms_lvl[i] = v; ms_run[i] = 0; end
        end
      end
      mb_d2 = mb_d1; mb_d1 = b;
      ms_d2 = ms_d1; ms_d1 = s;
    end
    #1;
  endtask

  function automatic logic [19:0] dut_vec();
    return {btn_hold, btn_release, btn_press, sw_level, btn_level};
  endfunction

  function automatic logic [19:0] model_vec();
    return {m_hold, m_rel, m_press, ms_lvl, mb_lvl};
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec() !== 20'h0) $display("FAIL reset_state got %h want 00000", dut_vec());
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL reset_idle cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_press();
    int unsigned hit = 999;
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL press_cycle cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (hit == 999 && btn_level[0]) hit = c;
    end
    n_chk++;
    if (hit != 10) $display("FAIL press_latency got %0d want 10", hit);
    else n_pass++;
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL press_release cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int unsigned hit = 999;
    int unsigned early = 0;
    btn_raw[1] = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 7) btn_raw[1] = 1'b1;
      if (c == 9) btn_raw[1] = 1'b0;
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL bounce_cycle cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (btn_level[1]) early++;
    end
    for (int c = 8; c <= 20; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL bounce_hold cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (hit == 999 && btn_level[1]) hit = c;
    end
    n_chk++;
    if (early != 0) $display("FAIL bounce_reject got %0d level-high cycles want 0", early);
    else n_pass++;
    n_chk++;
    if (hit != 10) $display("FAIL bounce_latency got %0d want 10", hit);
    else n_pass++;
    btn_raw[1] = 1'b1;
    repeat (15) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL bounce_release got %h want %h", dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    int unsigned pulses[$];
    int unsigned rel = 999;
    int unsigned late = 0;
    btn_raw[2] = 1'b0;
    for (int c = 1; c <= 20 && !btn_level[2]; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL hold_rise cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL hold_cycle k %0d got %h want %h", k, dut_vec(), model_vec());
      else n_pass++;
      if (btn_hold[2]) pulses.push_back(k);
    end
    n_chk++;
    if (pulses.size() != 5) $display("FAIL hold_count got %0d want 5", pulses.size());
    else n_pass++;
    foreach (pulses[j]) begin
      n_chk++;
      if (pulses[j] != HOLD + REP * j) $display("FAIL hold_offset idx %0d got %0d want %0d", j, pulses[j], HOLD + REP * j);
      else n_pass++;
    end
    btn_raw[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL hold_release cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (rel == 999 && btn_release[2]) rel = c;
      if (btn_hold[2]) late++;
    end
    n_chk++;
    if (rel != 10) $display("FAIL hold_release_latency got %0d want 10", rel);
    else n_pass++;
    n_chk++;
    if (late != 0) $display("FAIL hold_after_release got %0d pulses want 0", late);
    else n_pass++;
  endtask

  task automatic test_switch();
    int unsigned hit = 999;
    int unsigned ev = 0;
    sw_raw = 4'b1010;
    for (int c = 1; c <= 14; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL switch_cycle cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (hit == 999 && sw_level == 4'b1010) hit = c;
      if ({btn_press, btn_release, btn_hold} != 12'h0) ev++;
    end
    n_chk++;
    if (hit != 10) $display("FAIL switch_latency got %0d want 10", hit);
    else n_pass++;
    n_chk++;
    if (ev != 0) $display("FAIL switch_events got %0d event cycles want 0", ev);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int unsigned holds = 0;
    int unsigned hit = 999;
    btn_raw[3] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL midhold_cycle cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (btn_hold[3]) holds++;
    end
    n_chk++;
    if (holds != 2) $display("FAIL midhold_pulses got %0d want 2", holds);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (dut_vec() !== 20'h0) $display("FAIL async_reset got %h want 00000", dut_vec());
    else n_pass++;
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL post_reset cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
      if (hit == 999 && btn_press[3]) hit = c;
    end
    n_chk++;
    if (hit != 10) $display("FAIL post_reset_press got %0d want 10", hit);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned tb_[4];
    int unsigned ts_[4];
    for (int i = 0; i < 4; i++) begin
      tb_[i] = $urandom_range(1, 10);
      ts_[i] = $urandom_range(1, 10);
    end
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (tb_[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          tb_[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(30, 80) : $urandom_range(0, 12);
        end else tb_[i]--;
        if (ts_[i] == 0) begin
          sw_raw[i] = ~sw_raw[i];
          ts_[i] = $urandom_range(0, 14);
        end else ts_[i]--;
      end
      step();
      n_chk++;
      if (dut_vec() !== model_vec()) $display("FAIL random cyc %0d got %h want %h", c, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    btn_raw = '1;
    sw_raw  = '0;
    rst_n   = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_press();
    test_bounce();
    test_hold();
    test_switch();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
